// File: rtl/ccc_phase_step_ctrl.sv
// ccc_phase_step_ctrl: CCC PLL power-up/lock sequencer and phase-rotate stepper (CCC_PHASE_CTRL_RELOCK_EN enables abort-and-relock on lock loss)
module ccc_phase_step_ctrl #(
  parameter int PWRDN_CYC    = 16,
  parameter int LOCK_TIMEOUT = 4096,
  parameter int ROT_GAP      = 4,
  parameter int CNT_W        = 6,
  parameter int POS_W        = 6
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             pll_lock_i,
  output logic             pll_powerdown_n_o,
  input  logic             step_req_i,
  input  logic [1:0]       step_sel_i,
  input  logic             step_dir_i,
  input  logic [CNT_W-1:0] step_cnt_i,
  input  logic             load_req_i,
  output logic             step_ack_o,
  output logic             phase_out0_sel_o,
  output logic             phase_out2_sel_o,
  output logic             phase_out3_sel_o,
  output logic             phase_direction_o,
  output logic             phase_rotate_o,
  output logic             load_phase_n_o,
  output logic [POS_W-1:0] phase_pos0_o,
  output logic [POS_W-1:0] phase_pos2_o,
  output logic [POS_W-1:0] phase_pos3_o,
  output logic             ready_o,
  output logic             lock_lost_o,
  output logic             timeout_o
);
  localparam int TW = $clog2(LOCK_TIMEOUT) + 1;
  typedef enum logic [3:0] {PWRDN, WAIT_LOCK, IDLE, SETUP, ROT_HI, ROT_LO, LOAD, DONE, FAIL} state_e;
  state_e state_q;
  logic [TW-1:0] cnt_q;
  logic [CNT_W-1:0] rem_q;
  logic [POS_W-1:0] pos0_q, pos2_q, pos3_q, pos_inc;
  logic lock_s1_q, lock_s2_q, pwrdn_n_q, out0_q, out2_q, out3_q, dir_q, rot_q, load_n_q;
  logic ack_q, ready_q, lost_q, tmo_q, gap_end, lost_now;
  assign pos_inc  = dir_q ? POS_W'(1) : '1;
  assign gap_end  = cnt_q == TW'(ROT_GAP - 1);
  assign lost_now = !lock_s2_q && (state_q inside {IDLE, SETUP, ROT_HI, ROT_LO, LOAD, DONE});
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q   <= PWRDN;
      cnt_q     <= '0;
      rem_q     <= '0;
      pos0_q    <= '0;
      pos2_q    <= '0;
      pos3_q    <= '0;
      lock_s1_q <= 1'b0;
      lock_s2_q <= 1'b0;
      pwrdn_n_q <= 1'b0;
      out0_q    <= 1'b0;
      out2_q    <= 1'b0;
      out3_q    <= 1'b0;
      dir_q     <= 1'b0;
      rot_q     <= 1'b0;
      load_n_q  <= 1'b1;
      ack_q     <= 1'b0;
      ready_q   <= 1'b0;
      lost_q    <= 1'b0;
      tmo_q     <= 1'b0;
    end else begin
      lock_s1_q <= pll_lock_i;
      lock_s2_q <= lock_s1_q;
      ack_q     <= 1'b0;
      ready_q   <= 1'b0;
      rot_q     <= 1'b0;
      cnt_q     <= cnt_q + 1'b1;
      if (lost_now) lost_q <= 1'b1;
`ifdef CCC_PHASE_CTRL_RELOCK_EN
      if (lost_now) begin
        state_q   <= PWRDN;
        cnt_q     <= '0;
        pwrdn_n_q <= 1'b0;
        out0_q    <= 1'b0;
        out2_q    <= 1'b0;
        out3_q    <= 1'b0;
        dir_q     <= 1'b0;
        load_n_q  <= 1'b1;
        pos0_q    <= '0;
        pos2_q    <= '0;
        pos3_q    <= '0;
        ack_q     <= state_q inside {SETUP, ROT_HI, ROT_LO, LOAD};
      end else
`endif
      case (state_q)
        PWRDN: if (cnt_q == TW'(PWRDN_CYC - 1)) begin
          pwrdn_n_q <= 1'b1;
          cnt_q     <= '0;
          state_q   <= WAIT_LOCK;
        end
        WAIT_LOCK: if (lock_s2_q) begin
          ready_q <= 1'b1;
          state_q <= IDLE;
        end else if (cnt_q == TW'(LOCK_TIMEOUT - 1)) begin
          tmo_q   <= 1'b1;
          state_q <= FAIL;
        end
        IDLE: begin
          cnt_q <= '0;
          if (load_req_i) begin
            load_n_q <= 1'b0;
            pos0_q   <= '0;
            pos2_q   <= '0;
            pos3_q   <= '0;
            state_q  <= LOAD;
          end else if (step_req_i && step_cnt_i == '0) begin
            ack_q   <= 1'b1;
            state_q <= DONE;
          end else if (step_req_i) begin
            out0_q  <= step_sel_i[0] == step_sel_i[1];
            out2_q  <= step_sel_i[0];
            out3_q  <= step_sel_i[1];
            dir_q   <= step_dir_i;
            rem_q   <= step_cnt_i;
            state_q <= SETUP;
          end else ready_q <= lock_s2_q;
        end
        SETUP: if (gap_end) begin
          rot_q   <= 1'b1;
          state_q <= ROT_HI;
        end
        ROT_HI: begin
          cnt_q   <= '0;
          rem_q   <= rem_q - 1'b1;
          pos0_q  <= out0_q ? pos0_q + pos_inc : pos0_q;
          pos2_q  <= out2_q ? pos2_q + pos_inc : pos2_q;
          pos3_q  <= out3_q ? pos3_q + pos_inc : pos3_q;
          state_q <= ROT_LO;
        end
        ROT_LO: if (gap_end) begin
          if (rem_q != '0) begin
            rot_q   <= 1'b1;
            state_q <= ROT_HI;
          end else begin
            out0_q  <= 1'b0;
            out2_q  <= 1'b0;
            out3_q  <= 1'b0;
            dir_q   <= 1'b0;
            ack_q   <= 1'b1;
            state_q <= DONE;
          end
        end
        LOAD: if (gap_end) begin
          load_n_q <= 1'b1;
          ack_q    <= 1'b1;
          state_q  <= DONE;
        end
        DONE: begin
          cnt_q   <= '0;
          ready_q <= lock_s2_q;
          state_q <= IDLE;
        end
        default: ;
      endcase
    end
  end
  assign pll_powerdown_n_o = pwrdn_n_q;
  assign step_ack_o        = ack_q;
  assign phase_out0_sel_o  = out0_q;
  assign phase_out2_sel_o  = out2_q;
  assign phase_out3_sel_o  = out3_q;
  assign phase_direction_o = dir_q;
  assign phase_rotate_o    = rot_q;
  assign load_phase_n_o    = load_n_q;
  assign phase_pos0_o      = pos0_q;
  assign phase_pos2_o      = pos2_q;
  assign phase_pos3_o      = pos3_q;
  assign ready_o           = ready_q;
  assign lock_lost_o       = lost_q;
  assign timeout_o         = tmo_q;
endmodule
